led_bar_sequencer: RTL and testbench

Generates the 2-bit source select for the front-panel LED bar multiplexer, which chooses among CPU data-out, CPU data-in, debug register and port FF data. The block synchronizes and debounces the raw select switches and a mode pushbutton. It offers manual selection or an auto-scan mode that rotates through all four sources at a fixed dwell time. It sits between the board switch pins and the select input of the LED bar mux.

---
 rtl/led_bar_sequencer.sv | 80 ++++++++
 tb/tb_led_bar_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/led_bar_sequencer.sv
// led_bar_sequencer: synchronizes and debounces the LED bar select switches and mode button, then drives the mux select manually or by timed auto-scan
// Ports: clock/reset_n (async active-low) | sw_raw, auto_btn_n (raw, async), hold (sync freeze)
//        led_sel (mux select), auto_mode (auto-scan active), sel_changed (pulse on new led_sel)
module led_bar_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] sw_raw,
  input  logic       auto_btn_n,
  input  logic       hold,
  output logic [1:0] led_sel,
  output logic       auto_mode,
  output logic       sel_changed
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int DWW = $clog2(DWELL_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_CYCLES - 1);
  localparam logic MANUAL = 1'b0;
  localparam logic AUTO = 1'b1;
  // bit 2 is the button, bits 1:0 the switches; the button idles high
  logic [2:0] rawMeta, rawSync, stable;
  logic [DBW-1:0] dbCnt [3];
  logic btnPrev, state, stateNext, pressEvent;
  logic [DWW-1:0] dwellCnt, dwellNext;
  logic [1:0] ledNext;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rawMeta <= 3'b100;
      rawSync <= 3'b100;
    end else begin
      rawMeta <= {auto_btn_n, sw_raw};
      rawSync <= rawMeta;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable <= 3'b100;
      for (int k = 0; k < 3; k++) dbCnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rawSync[k] == stable[k]) dbCnt[k] <= '0;
        else if (dbCnt[k] == DB_LAST) begin
          stable[k] <= rawSync[k];
          dbCnt[k] <= '0;
        end else dbCnt[k] <= dbCnt[k] + 1'b1;
      end
    end
  end
  assign pressEvent = btnPrev & ~stable[2];
  // a press toggles the mode and suppresses any led_sel update that cycle, including a dwell wrap
  always_comb begin
    stateNext = pressEvent ? ~state : state;
    dwellNext = pressEvent ? '0
              : (state == AUTO && !hold) ? (dwellCnt == DWELL_LAST ? '0 : dwellCnt + 1'b1)
              : dwellCnt;
    ledNext = (pressEvent || hold) ? led_sel
            : (state == MANUAL) ? stable[1:0]
            : (dwellCnt == DWELL_LAST) ? led_sel + 2'd1
            : led_sel;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= MANUAL;
      dwellCnt <= '0;
      led_sel <= 2'b00;
      sel_changed <= 1'b0;
      btnPrev <= 1'b1;
    end else begin
      state <= stateNext;
      dwellCnt <= dwellNext;
      led_sel <= ledNext;
      sel_changed <= ledNext != led_sel;
      btnPrev <= stable[2];
    end
  end
  assign auto_mode = state;
endmodule

// File: tb/tb_led_bar_sequencer.sv
// tb_led_bar_sequencer: directed checks of led_bar_sequencer with DEBOUNCE_CYCLES=4, DWELL_CYCLES=8
module tb_led_bar_sequencer;
  logic clock = 1'b0;
  logic reset_n;
  logic [1:0] sw_raw;
  logic auto_btn_n;
  logic hold;
  logic [1:0] led_sel;
  logic auto_mode;
  logic sel_changed;
  int compared = 0;
  int mismatched = 0;

  led_bar_sequencer #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8)) dut (
    .clock(clock), .reset_n(reset_n), .sw_raw(sw_raw), .auto_btn_n(auto_btn_n),
    .hold(hold), .led_sel(led_sel), .auto_mode(auto_mode), .sel_changed(sel_changed)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // exp = {led_sel, auto_mode, sel_changed}
  task automatic check(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {led_sel, auto_mode, sel_changed};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] prev;
    logic [1:0] seq [3];
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10;
    reset_n = 1'b0; sw_raw = 2'b11; auto_btn_n = 1'b1; hold = 1'b0;
    step(3);
    check("reset_state", 4'b00_0_0);
    reset_n = 1'b1;
    step(6); check("rst_pre_load", 4'b00_0_0);
    step(1); check("rst_load_edge7", 4'b11_0_1);
    step(1); check("rst_pulse_end", 4'b11_0_0);
    sw_raw = 2'b00;
    step(6); check("sw00_pre", 4'b11_0_0);
    step(1); check("sw00_load", 4'b00_0_1);
    step(3); check("sw00_settled", 4'b00_0_0);
    sw_raw = 2'b10;
    step(3);
    sw_raw = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step(1); check("glitch_ignored", 4'b00_0_0);
    end
    sw_raw = 2'b10;
    step(6); check("sw10_pre", 4'b00_0_0);
    step(1); check("sw10_load_edge7", 4'b10_0_1);
    step(1); check("sw10_pulse_end", 4'b10_0_0);
    auto_btn_n = 1'b0;
    step(6); check("press_pre", 4'b10_0_0);
    step(1); check("auto_enter", 4'b10_1_0);
    step(3); auto_btn_n = 1'b1;
    step(4); check("dwell1_pre", 4'b10_1_0);
    step(1); check("dwell1_adv", 4'b11_1_1);
    step(1); check("dwell1_end", 4'b11_1_0);
    prev = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(6); check("scan_pre", {prev, 2'b10});
      step(1); check("scan_adv", {seq[i], 2'b11});
      step(1); check("scan_end", {seq[i], 2'b10});
      prev = seq[i];
    end
    step(2);
    hold = 1'b1;
    step(5); check("hold_frozen", 4'b10_1_0);
    hold = 1'b0;
    step(4); check("hold_ext_pre", 4'b10_1_0);
    step(1); check("hold_ext_adv", 4'b11_1_1);
    hold = 1'b1; auto_btn_n = 1'b0;
    step(6); check("hold_toggle_pre", 4'b11_1_0);
    step(1); check("hold_toggle_manual", 4'b11_0_0);
    auto_btn_n = 1'b1;
    step(3); check("hold_still_frozen", 4'b11_0_0);
    hold = 1'b0;
    step(1); check("hold_drop_load", 4'b10_0_1);
    step(5); check("pre_simul", 4'b10_0_0);
    auto_btn_n = 1'b0;
    step(2); sw_raw = 2'b01;
    step(2); auto_btn_n = 1'b1;
    step(3); check("simul_auto", 4'b10_1_0);
    step(1); auto_btn_n = 1'b0;
    step(6); check("simul_pre_tc", 4'b10_1_0);
    step(1); check("simul_toggle_wins", 4'b10_0_0);
    step(1); check("simul_manual_load", 4'b01_0_1);
    auto_btn_n = 1'b1;
    step(6); check("rearm", 4'b01_0_0);
    auto_btn_n = 1'b0;
    step(7); check("auto2_enter", 4'b01_1_0);
    step(7); check("auto2_pre", 4'b01_1_0);
    step(1); check("auto2_adv1", 4'b10_1_1);
    step(8); check("auto2_adv2", 4'b11_1_1);
    reset_n = 1'b0;
    #1 check("async_reset", 4'b00_0_0);
    step(2); check("reset_held", 4'b00_0_0);
    auto_btn_n = 1'b1;
    reset_n = 1'b1;
    step(6); check("post_rst_pre", 4'b00_0_0);
    step(1); check("post_rst_manual", 4'b01_0_1);
    step(3); check("post_rst_settled", 4'b01_0_0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
